stream_frame_checker: RTL and testbench

- Downstream consumer of the registered en/data byte stream produced by the pass-through stage.
- Groups each contiguous run of en-qualified beats into one frame and checks its length bounds and trailing XOR checksum.
- Emits a one-cycle per-frame status report and keeps saturating good/bad frame counters for the scoreboard and for software.

---
 rtl/stream_frame_checker.sv | 135 +++++++++++++
 tb/tb_stream_frame_checker.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/stream_frame_checker.sv
// Groups each run of rx_en beats into a frame and checks length bounds and trailing XOR checksum.
// The report is registered and appears one cycle after the gap edge; there is no backpressure.
module stream_frame_checker #(
  parameter int DATA_WIDTH = 8,
  parameter int MIN_LEN    = 4,
  parameter int MAX_LEN    = 64,
  parameter int LEN_W      = 7,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_en,
  input  logic [DATA_WIDTH-1:0] rx_data,
  output logic                  busy,
  output logic                  frm_valid,
  output logic [LEN_W-1:0]      frm_len,
  output logic                  frm_ok,
  output logic                  frm_err_len,
  output logic                  frm_err_chk,
  output logic [CNT_W-1:0]      good_cnt,
  output logic [CNT_W-1:0]      bad_cnt
);

  localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_LEN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_DROP
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [LEN_W-1:0]      r_len_cnt;
  logic [LEN_W-1:0]      w_len_nxt;
  logic [LEN_W-1:0]      w_len_inc;
  logic [DATA_WIDTH-1:0] r_xor_acc;
  logic [DATA_WIDTH-1:0] w_xor_nxt;
  logic                  w_end;
  logic                  w_err_len;
  logic                  w_err_chk;

  logic                  r_frm_valid;
  logic [LEN_W-1:0]      r_frm_len;
  logic                  r_frm_ok;
  logic                  r_frm_err_len;
  logic                  r_frm_err_chk;
  logic [CNT_W-1:0]      r_good_cnt;
  logic [CNT_W-1:0]      r_bad_cnt;

  always_comb begin
    w_state_nxt = r_state;
    w_len_nxt   = r_len_cnt;
    w_xor_nxt   = r_xor_acc;
    w_end       = 1'b0;
    w_len_inc   = r_len_cnt + LEN_W'(1);
    case (r_state)
      S_IDLE: begin
        if (rx_en) begin
          w_state_nxt = S_RECV;
          w_len_nxt   = LEN_W'(1);
          w_xor_nxt   = rx_data;
        end
      end
      S_RECV: begin
        if (rx_en) begin
          w_len_nxt = w_len_inc;
          w_xor_nxt = r_xor_acc ^ rx_data;
          if (w_len_inc == LEN_SAT) begin
            w_state_nxt = S_DROP;
          end
        end else begin
          w_end       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_DROP: begin
        // Overlong frame: swallow beats with length pinned at the saturation value.
        if (!rx_en) begin
          w_end       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Checksum only matters once the length is legal.
  assign w_err_len = (r_len_cnt < LEN_MIN) || (r_len_cnt == LEN_SAT);
  assign w_err_chk = !w_err_len && (r_xor_acc != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_len_cnt     <= '0;
      r_xor_acc     <= '0;
      r_frm_valid   <= 1'b0;
      r_frm_len     <= '0;
      r_frm_ok      <= 1'b0;
      r_frm_err_len <= 1'b0;
      r_frm_err_chk <= 1'b0;
      r_good_cnt    <= '0;
      r_bad_cnt     <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_len_cnt   <= w_len_nxt;
      r_xor_acc   <= w_xor_nxt;
      r_frm_valid <= w_end;
      if (w_end) begin
        r_frm_len     <= r_len_cnt;
        r_frm_ok      <= !w_err_len && !w_err_chk;
        r_frm_err_len <= w_err_len;
        r_frm_err_chk <= w_err_chk;
        if (!w_err_len && !w_err_chk) begin
          if (r_good_cnt != '1) r_good_cnt <= r_good_cnt + CNT_W'(1);
        end else begin
          if (r_bad_cnt != '1) r_bad_cnt <= r_bad_cnt + CNT_W'(1);
        end
      end
    end
  end

  assign busy        = (r_state != S_IDLE);
  assign frm_valid   = r_frm_valid;
  assign frm_len     = r_frm_len;
  assign frm_ok      = r_frm_ok;
  assign frm_err_len = r_frm_err_len;
  assign frm_err_chk = r_frm_err_chk;
  assign good_cnt    = r_good_cnt;
  assign bad_cnt     = r_bad_cnt;

endmodule

// File: tb/tb_stream_frame_checker.sv
// Scoreboard bench for stream_frame_checker: expected reports are queued as frames are driven
// and compared field by field whenever frm_valid pulses.
module tb_stream_frame_checker;

  localparam int DW = 8;
  localparam int MINL = 4;
  localparam int MAXL = 64;
  localparam int LW = 7;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          rx_en;
  logic [DW-1:0] rx_data;
  logic          busy;
  logic          frm_valid;
  logic [LW-1:0] frm_len;
  logic          frm_ok;
  logic          frm_err_len;
  logic          frm_err_chk;
  logic [CW-1:0] good_cnt;
  logic [CW-1:0] bad_cnt;

  always #5 clk = ~clk;

  stream_frame_checker #(
    .DATA_WIDTH(DW), .MIN_LEN(MINL), .MAX_LEN(MAXL), .LEN_W(LW), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx_en(rx_en), .rx_data(rx_data),
    .busy(busy), .frm_valid(frm_valid), .frm_len(frm_len), .frm_ok(frm_ok),
    .frm_err_len(frm_err_len), .frm_err_chk(frm_err_chk),
    .good_cnt(good_cnt), .bad_cnt(bad_cnt)
  );

  typedef struct {
    logic [LW-1:0] len;
    logic          ok;
    logic          el;
    logic          ec;
    logic [CW-1:0] g;
    logic [CW-1:0] b;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  int            n_checks = 0;
  int            n_pass = 0;
  int            n_reports = 0;
  int            n_pushed = 0;
  logic [CW-1:0] m_good = '0;
  logic [CW-1:0] m_bad = '0;
  logic [7:0]    fq[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic void model(input logic [7:0] b[$]);
    exp_t e;
    int   n;
    logic [7:0] x;
    n = b.size();
    x = '0;
    foreach (b[i]) if (i < MAXL) x = x ^ b[i];
    e.len = (n > MAXL) ? LW'(MAXL + 1) : LW'(n);
    e.el  = (n < MINL) || (n > MAXL);
    e.ec  = !e.el && (x != 8'h00);
    e.ok  = !e.el && !e.ec;
    if (e.ok) begin
      if (m_good != '1) m_good = m_good + 1'b1;
    end else begin
      if (m_bad != '1) m_bad = m_bad + 1'b1;
    end
    e.g = m_good;
    e.b = m_bad;
    sb.push_back(e);
    n_pushed++;
  endfunction

  always @(negedge clk) begin
    if (rst_n === 1'b1 && frm_valid === 1'b1) begin
      n_reports++;
      if (sb.size() == 0) begin
        check("unexpected_report", 32'd1, 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check("frm_len", 32'(frm_len), 32'(mon_e.len));
        check("frm_ok", 32'(frm_ok), 32'(mon_e.ok));
        check("frm_err_len", 32'(frm_err_len), 32'(mon_e.el));
        check("frm_err_chk", 32'(frm_err_chk), 32'(mon_e.ec));
        check("good_cnt", 32'(good_cnt), 32'(mon_e.g));
        check("bad_cnt", 32'(bad_cnt), 32'(mon_e.b));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      rx_en   = 1'b0;
      rx_data = '0;
    end
  endtask

  // Drives the frame then one gap beat; optional checks run mid-frame.
  task automatic send(input logic [7:0] beats[$], input bit chk_busy, input bit chk_overlap);
    model(beats);
    foreach (beats[i]) begin
      @(posedge clk); #1;
      rx_en   = 1'b1;
      rx_data = beats[i];
      if (chk_overlap && i == 0) begin
        @(negedge clk);
        check("b2b_overlap_vld", 32'(frm_valid), 32'd1);
      end
      if (chk_busy && i > 0) begin
        @(negedge clk);
        check("busy_in_frame", 32'(busy), 32'd1);
        check("no_early_report", 32'(frm_valid), 32'd0);
      end
    end
    @(posedge clk); #1;
    rx_en   = 1'b0;
    rx_data = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_vld"}, 32'(frm_valid), 32'd0);
    check({tag, "_len"}, 32'(frm_len), 32'd0);
    check({tag, "_ok"}, 32'(frm_ok), 32'd0);
    check({tag, "_el"}, 32'(frm_err_len), 32'd0);
    check({tag, "_ec"}, 32'(frm_err_chk), 32'd0);
    check({tag, "_good"}, 32'(good_cnt), 32'd0);
    check({tag, "_bad"}, 32'(bad_cnt), 32'd0);
  endtask

  initial begin
    int waited;
    rst_n   = 1'b0;
    rx_en   = 1'b0;
    rx_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(2);

    fq = '{8'h11, 8'h22, 8'h33, 8'h00};
    send(fq, 1'b0, 1'b0);
    idle(3);

    fq = '{8'h11, 8'h22, 8'h33, 8'h01};
    send(fq, 1'b0, 1'b0);
    idle(3);

    fq = '{8'hA0, 8'h0A, 8'hAA};
    send(fq, 1'b0, 1'b0);
    idle(3);

    fq.delete();
    repeat (70) fq.push_back(8'h00);
    send(fq, 1'b1, 1'b0);
    idle(3);

    fq = '{8'h11, 8'h22, 8'h33, 8'h00};
    send(fq, 1'b0, 1'b0);
    fq = '{8'h11, 8'h22, 8'h33, 8'h01};
    send(fq, 1'b0, 1'b1);
    idle(3);

    // Abort a frame with reset after two beats.
    @(posedge clk); #1;
    rx_en = 1'b1; rx_data = 8'h11;
    @(posedge clk); #1;
    rx_data = 8'h22;
    @(posedge clk); #1;
    rst_n = 1'b0; rx_en = 1'b0; rx_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("midreset");
    m_good = '0;
    m_bad  = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    fq = '{8'h11, 8'h22, 8'h33, 8'h00};
    send(fq, 1'b0, 1'b0);

    waited = 0;
    while (sb.size() != 0 && waited < 50) begin
      @(posedge clk);
      waited++;
    end
    idle(3);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    check("report_count", 32'(n_reports), 32'(n_pushed));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
